// File: rtl/rv_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_loader_pkg;

    // Frame layout: two-byte little-endian length header, four-byte words.
    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 8 * LEN_BYTES;
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int IDX_W      = $clog2(WORD_BYTES);

    // Loader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // States in which the loader consumes stream bytes.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready gates the byte stream; the memory side never stalls.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Host side: drives the byte stream and observes the memory writes.
    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side: consumes the byte stream and issues memory writes.
    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words.
// Latency: word/word_valid are combinational in the cycle of the fourth byte.
// Backpressure: none; a byte is taken whenever byte_en is high.
module imem_word_assembler
    import rv_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_sh;

    // Newest byte enters at the top so byte 0 ends up in bits [7:0].
    assign word       = {byte_in, r_sh[WORD_W-1:8]};
    assign word_valid = byte_en && (r_idx == IDX_W'(WORD_BYTES - 1));

    // Byte index and shift register; index wraps naturally after the last byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_sh  <= '0;
        end else if (clr) begin
            r_idx <= '0;
            r_sh  <= '0;
        end else if (byte_en) begin
            r_idx <= r_idx + IDX_W'(1);
            r_sh  <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed program loader: length header, packed payload words, XOR checksum.
// Latency: imem write registered one cycle after byte 3; status one cycle after deciding byte.
// Backpressure: in_ready high only while loading; memory writes never stall.
module imem_loader
    import rv_loader_pkg::*;
#(
    parameter int ADDR_W = 8
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Largest legal image in words; 17 bits so 2^16 stays representable.
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_wcnt;
    logic [7:0]         r_csum;
    logic               r_in_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_core_rst_n;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [WORD_W-1:0]  r_wdata;

    logic               w_xfer;
    logic               w_asm_clr;
    logic               w_byte_en;
    logic               w_word_valid;
    logic [WORD_W-1:0]  w_word;
    logic [LEN_W-1:0]   w_len_full;
    logic [LEN_W-1:0]   w_wcnt_inc;
    logic               w_len_big;

    assign w_xfer     = bus.in_valid && r_in_ready;
    assign w_len_full = {bus.in_data, r_len[7:0]};
    assign w_len_big  = {1'b0, w_len_full} > MAX_WORDS;
    assign w_wcnt_inc = r_wcnt + LEN_W'(1);

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_asm_clr),
        .byte_en    (w_byte_en),
        .byte_in    (bus.in_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus assembler controls.
    always_comb begin
        w_state_nxt = r_state;
        w_asm_clr   = 1'b0;
        w_byte_en   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_state_nxt = ST_LEN0;
                    w_asm_clr   = 1'b1;
                end
            end
            ST_LEN0: begin
                if (w_xfer) w_state_nxt = ST_LEN1;
            end
            ST_LEN1: begin
                if (w_xfer) begin
                    if (w_len_big)               w_state_nxt = ST_ERR;
                    else if (w_len_full == '0)   w_state_nxt = ST_CSUM;
                    else                         w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_byte_en = w_xfer;
                if (w_word_valid && (w_wcnt_inc == r_len)) w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_xfer) w_state_nxt = (bus.in_data == r_csum) ? ST_DONE : ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Length capture, word counter, checksum and the registered memory write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len   <= '0;
            r_wcnt  <= '0;
            r_csum  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_word_valid;
            if (w_asm_clr) begin
                r_wcnt <= '0;
                r_csum <= '0;
            end
            if (r_state == ST_LEN0 && w_xfer) r_len[7:0]  <= bus.in_data;
            if (r_state == ST_LEN1 && w_xfer) r_len[15:8] <= bus.in_data;
            if (w_byte_en) r_csum <= r_csum ^ bus.in_data;
            if (w_word_valid) begin
                r_addr  <= r_wcnt[ADDR_W-1:0];
                r_wdata <= w_word;
                r_wcnt  <= w_wcnt_inc;
            end
        end
    end

    // Status outputs registered from the next state so they move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_in_ready   <= is_busy(w_state_nxt);
            r_busy       <= is_busy(w_state_nxt);
            r_done       <= (w_state_nxt == ST_DONE);
            r_err        <= (w_state_nxt == ST_ERR);
            r_core_rst_n <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign core_rst_n     = r_core_rst_n;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule
